// File: rtl/rgmii_inband_pkg.sv
// Shared encodings for the RGMII in-band status decoder: speed codes, field positions, states.
package rgmii_inband_pkg;

    localparam int unsigned FIELD_W = 4;

    localparam logic [1:0] SPEED_10M   = 2'b00;
    localparam logic [1:0] SPEED_100M  = 2'b01;
    localparam logic [1:0] SPEED_1000M = 2'b10;
    localparam logic [1:0] SPEED_RSVD  = 2'b11;

    localparam int unsigned LINK_BIT   = 0;
    localparam int unsigned SPEED_LSB  = 1;
    localparam int unsigned DUPLEX_BIT = 3;

    typedef enum logic {
        ST_UNKNOWN = 1'b0,
        ST_VALID   = 1'b1
    } state_e;

    function automatic logic speed_is_legal(input logic [1:0] spd);
        return (spd == SPEED_10M) || (spd == SPEED_100M) || (spd == SPEED_1000M);
    endfunction

endpackage

// File: rtl/rgmii_inband_filter.sv
// Debounce filter: holds a candidate status nibble and counts consecutive matching qualified
// samples, saturating at FILTER_LEN; commit is asserted while the count is saturated.
module rgmii_inband_filter
    import rgmii_inband_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               qualified,
    input  logic               invalid,
    input  logic [FIELD_W-1:0] sample,
    output logic               commit,
    output logic [FIELD_W-1:0] candidate
);

    localparam logic [7:0] COUNT_MAX = 8'(FILTER_LEN);

    logic [7:0]         count_q, count_d;
    logic [FIELD_W-1:0] cand_q, cand_d;

    always_comb begin
        count_d = count_q;
        cand_d  = cand_q;
        if (clear) begin
            count_d = '0;
            cand_d  = '0;
        end else if (qualified) begin
            if (sample == cand_q) begin
                if (count_q < COUNT_MAX) begin
                    count_d = count_q + 8'd1;
                end
            end else begin
                cand_d  = sample;
                count_d = 8'd1;
            end
        end else if (invalid) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            cand_q  <= '0;
        end else begin
            count_q <= count_d;
            cand_q  <= cand_d;
        end
    end

    assign commit    = (count_q == COUNT_MAX);
    assign candidate = cand_q;

endmodule

// File: rtl/rgmii_inband_status.sv
// RGMII in-band link status decoder with debounce and staleness timeout.
// Optional change_count output enabled by defining RGMII_INBAND_CHANGE_CNT_EN.
module rgmii_inband_status
    import rgmii_inband_pkg::*;
#(
    parameter int unsigned FILTER_LEN    = 8,
    parameter int unsigned STALE_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic        link_up,
    output logic [1:0]  speed_out,
    output logic        full_duplex,
    output logic        status_valid,
    output logic        status_change
`ifdef RGMII_INBAND_CHANGE_CNT_EN
    ,
    output logic [15:0] change_count
`endif
);

    localparam int unsigned         STALE_W   = $clog2(STALE_TIMEOUT + 1);
    localparam logic [STALE_W-1:0]  STALE_MAX = STALE_W'(STALE_TIMEOUT);

    logic               line_idle, qualified, invalid;
    logic               commit, timeout;
    logic [FIELD_W-1:0] candidate;

    logic [STALE_W-1:0] stale_q, stale_d;
    state_e             state_q, state_d;
    logic               link_q, link_d;
    logic [1:0]         speed_q, speed_d;
    logic               duplex_q, duplex_d;
    logic               change_q, change_d;

    assign line_idle = !gmii_rx_dv && !gmii_rx_er;
    assign qualified = line_idle && (gmii_rxd[3:0] == gmii_rxd[7:4])
                       && speed_is_legal(gmii_rxd[SPEED_LSB +: 2]);
    assign invalid   = line_idle && !qualified;

    // A qualified sample on the would-be timeout cycle rescues the status.
    assign timeout = (state_q == ST_VALID) && !qualified && (stale_q >= STALE_MAX - 1'b1);

    rgmii_inband_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk       (clk),
        .rst       (rst),
        .clear     (timeout),
        .qualified (qualified),
        .invalid   (invalid),
        .sample    (gmii_rxd[FIELD_W-1:0]),
        .commit    (commit),
        .candidate (candidate)
    );

    always_comb begin
        stale_d = stale_q;
        if (qualified) begin
            stale_d = '0;
        end else if (stale_q != STALE_MAX) begin
            stale_d = stale_q + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        link_d   = link_q;
        speed_d  = speed_q;
        duplex_d = duplex_q;
        change_d = 1'b0;
        if (timeout) begin
            state_d = ST_UNKNOWN;
            link_d  = 1'b0;
        end else if (commit) begin
            state_d = ST_VALID;
            link_d  = candidate[LINK_BIT];
            // Speed and duplex are meaningless while link is down, so keep the last known.
            if (candidate[LINK_BIT]) begin
                speed_d  = candidate[SPEED_LSB +: 2];
                duplex_d = candidate[DUPLEX_BIT];
            end
            change_d = (state_q == ST_UNKNOWN) || (link_d != link_q)
                       || (speed_d != speed_q) || (duplex_d != duplex_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stale_q  <= '0;
            state_q  <= ST_UNKNOWN;
            link_q   <= 1'b0;
            speed_q  <= SPEED_1000M;
            duplex_q <= 1'b0;
            change_q <= 1'b0;
        end else begin
            stale_q  <= stale_d;
            state_q  <= state_d;
            link_q   <= link_d;
            speed_q  <= speed_d;
            duplex_q <= duplex_d;
            change_q <= change_d;
        end
    end

    assign link_up       = link_q;
    assign speed_out     = speed_q;
    assign full_duplex   = duplex_q;
    assign status_valid  = (state_q == ST_VALID);
    assign status_change = change_q;

`ifdef RGMII_INBAND_CHANGE_CNT_EN
    logic [15:0] change_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            change_cnt_q <= '0;
        end else if (change_d) begin
            change_cnt_q <= change_cnt_q + 16'd1;
        end
    end

    assign change_count = change_cnt_q;
`endif

endmodule
